// File: rtl/mesh_pkg.sv
// mesh_pkg -- shared definitions for the mesh network-interface transmit path.
//
// Contents:
//   FLIT_LENGTH  total flit width (72 bits)
//   *_W          field widths of the flit layout
//   ni_state_e   injection FSM state encoding
//   pack_flit    assembles a flit from its fields
//
// Flit layout (MSB first):
//   [71:69] dst_x  [68:66] dst_y  [65:63] src_x  [62:60] src_y
//   [59:58] reserved (0)  [57:16] timestamp  [15:0] num
package mesh_pkg;

  localparam int FLIT_LENGTH = 72;
  localparam int COORD_W     = 3;
  localparam int RSVD_W      = 2;
  localparam int NUM_W       = 16;
  localparam int TS_W        = FLIT_LENGTH - 4 * COORD_W - RSVD_W - NUM_W;

  typedef enum logic {
    NI_IDLE = 1'b0,
    NI_SEND = 1'b1
  } ni_state_e;

  function automatic logic [FLIT_LENGTH-1:0] pack_flit(
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y,
    input logic [COORD_W-1:0] src_x,
    input logic [COORD_W-1:0] src_y,
    input logic [TS_W-1:0]    ts,
    input logic [NUM_W-1:0]   num
  );
    return {dst_x, dst_y, src_x, src_y, {RSVD_W{1'b0}}, ts, num};
  endfunction

endpackage

// File: rtl/ni_fifo.sv
// ni_fifo -- flit queue between the core side and the router side.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   wr_en_i         push wr_data_i at the tail (ignored when full)
//   wr_data_i       flit to push
//   rd_en_i         pop the head (ignored when empty)
//   rd_data_o       current head entry
//   count_o         occupancy, log2(DEPTH)+1 bits
//   full_o          occupancy == DEPTH
//
// Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH naturally.
// Storage itself is not reset; only pointers and count are.
module ni_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 72
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/mesh_ni_tx.sv
// mesh_ni_tx -- network-interface transmit side: assembles flits from the
// core, queues them, and injects them into a mesh router port.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   src_lx, src_ly            this node's coordinates, captured per flit
//   core_valid / core_ready   core-side handshake
//   core_dst_x, core_dst_y    destination coordinates
//   core_num                  flit number (zero-extended to 16 bits)
//   reqin / ackin             router-side handshake
//   datain                    flit toward the router (zero when reqin=0)
//   inj_count                 flits accepted by the router, wraps at 2^16
//   state_dbg                 current injection FSM state (0 IDLE, 1 SEND)
//
// Handshakes: a core transfer happens at a posedge where core_valid and
// core_ready are both 1; core_ready is !full and never looks at ackin.
// A router transfer happens at a posedge where reqin and ackin are both 1;
// ackin is ignored while reqin=0. reqin and datain hold steady until acked.
//
// Build option: define MESH_NI_TIMESTAMP_EN to stamp each flit with a
// 42-bit free-running cycle count; otherwise the timestamp field is zero.
module mesh_ni_tx
  import mesh_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             src_lx,
  input  logic [2:0]             src_ly,
  input  logic                   core_valid,
  output logic                   core_ready,
  input  logic [2:0]             core_dst_x,
  input  logic [2:0]             core_dst_y,
  input  logic [ID_W-1:0]        core_num,
  output logic                   reqin,
  input  logic                   ackin,
  output logic [FLIT_LENGTH-1:0] datain,
  output logic [15:0]            inj_count,
  output logic                   state_dbg
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  ni_state_e              state_q;
  logic                   reqin_q;
  logic [15:0]            inj_count_q;
  logic [TS_W-1:0]        ts_field;
  logic [NUM_W-1:0]       num_ext;
  logic [FLIT_LENGTH-1:0] flit_in, fifo_head;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   wr_en, pop, last_entry;

`ifdef MESH_NI_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + TS_W'(1);
  end

  // The value held before the transfer edge is the one stamped.
  assign ts_field = ts_q;
`else
  assign ts_field = '0;
`endif

  assign num_ext    = NUM_W'(core_num);
  assign flit_in    = pack_flit(core_dst_x, core_dst_y, src_lx, src_ly,
                                ts_field, num_ext);
  assign core_ready = !fifo_full;
  assign wr_en      = core_valid && core_ready;
  assign pop        = ackin && reqin_q;
  assign last_entry = (fifo_count == CNT_W'(1));

  ni_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_LENGTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (flit_in),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full)
  );

  // SEND exactly while the FIFO holds something; reqin_q is its registered
  // image, so a new write only shows on reqin after the write edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= NI_IDLE;
      reqin_q     <= 1'b0;
      inj_count_q <= '0;
    end else begin
      if (pop) inj_count_q <= inj_count_q + 16'd1;
      case (state_q)
        NI_IDLE: begin
          if (wr_en) begin
            state_q <= NI_SEND;
            reqin_q <= 1'b1;
          end
        end
        NI_SEND: begin
          if (pop && last_entry && !wr_en) begin
            state_q <= NI_IDLE;
            reqin_q <= 1'b0;
          end
        end
        default: begin
          state_q <= NI_IDLE;
          reqin_q <= 1'b0;
        end
      endcase
    end
  end

  assign reqin     = reqin_q;
  assign datain    = reqin_q ? fifo_head : '0;
  assign inj_count = inj_count_q;
  assign state_dbg = state_q;

endmodule

// File: doc/mesh_ni_tx.md
MESH_NI_TX -- requirements
Module: mesh_ni_tx

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-002 Parameter ID_W, default 16, flit-number field width.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-low reset; rst=0 resets immediately, release is synchronous to clk.
REQ-005 src_lx, src_ly  in  3 each  this node's mesh coordinates; sampled with each accepted flit.
REQ-006 core_valid  in  1  core offers a flit.
REQ-007 core_ready  out  1  FIFO can accept.
REQ-008 core_dst_x, core_dst_y  in  3 each  destination coordinates.
REQ-009 core_num  in  ID_W  flit number.
REQ-010 reqin  out  1  request to the mesh router port.
REQ-011 ackin  in  1  router accepts the flit on datain this cycle.
REQ-012 datain  out  FLIT_LENGTH  flit toward the router.
REQ-013 inj_count  out  16  flits handed to the router since reset.

Function
REQ-014 The flit layout SHALL be, from the MSB:
  - [FLIT_LENGTH-1 -: 3] dst_x
  - then 3 bits dst_y
  - then 3 bits src_x
  - then 3 bits src_y
  - then 2 bits reserved, driven 0
  - [FLIT_LENGTH-15:16] timestamp
  - [15:0] num, zero-extended from ID_W
REQ-015 A core transfer SHALL occur when core_valid and core_ready are both 1 at a posedge; the assembled flit is written to the FIFO tail.
REQ-016 core_ready SHALL equal !full; it SHALL NOT depend combinationally on ackin.
REQ-017 Two-state FSM:
  - IDLE: FIFO empty, reqin=0.
  - SEND: FIFO non-empty, reqin=1.
  - IDLE->SEND on a write.
  - SEND->IDLE when a pop leaves the FIFO empty and there is no simultaneous write.
REQ-018 Latency: a flit written at edge N SHALL raise reqin after edge N; there is no combinational path from core_valid to reqin.
REQ-019 datain SHALL equal the FIFO head while reqin=1, and all zeros otherwise.
REQ-020 ackin=1 at a posedge while reqin=1 SHALL pop the head and increment inj_count. ackin while reqin=0 SHALL be ignored.
REQ-021 A simultaneous write and pop SHALL keep occupancy unchanged, including when the FIFO is full. core_ready stays 0 when full, so no write occurs in that case.
REQ-022 Pointers SHALL wrap modulo DEPTH; occupancy SHALL use a log2(DEPTH)+1-bit count.
REQ-023 inj_count SHALL wrap from 16'hFFFF to 0.
REQ-024 A flit SHALL remain at the head, with datain stable, until acked; reqin SHALL NOT drop while the FIFO is non-empty.

Reset
REQ-025 On rst=0 the block SHALL clear:
  - FIFO pointers and count
  - FSM to IDLE
  - reqin=0, datain=0, inj_count=0
  - core_ready=1 once rst=1
  - timestamp counter
REQ-026 Reset mid-transfer SHALL discard all queued flits; no partial flit may appear after release.

Configuration
REQ-027 With MESH_NI_TIMESTAMP_EN defined:
  - a 42-bit free-running cycle counter increments every clk after reset and wraps at 2^42.
  - the timestamp field holds the counter value at the core-transfer edge.
REQ-028 Without MESH_NI_TIMESTAMP_EN: the counter SHALL NOT exist and the timestamp field SHALL be all zeros.

Structure
REQ-029 FLIT_LENGTH (72), field offsets and widths, and the FSM state enum SHALL live in the shared package mesh_pkg.
REQ-030 FIFO storage and pointers SHALL be the sub-module ni_fifo (parameter DEPTH, width FLIT_LENGTH); the FSM, flit assembly and counters stay in mesh_ni_tx.

Verification
REQ-031 Single flit: src=(0,0), dst=(1,1), num=5, ackin held 1 -> reqin rises one cycle after the write; datain[15:0]=5 and dst fields=(1,1); inj_count=1; reqin=0 one cycle later.
REQ-032 Backpressure: 5 writes with DEPTH=4 and ackin=0 -> core_ready=0 after the 4th write; reqin stays 1 with head num unchanged; releasing ackin drains nums in order 0..3, then 4.
REQ-033 Full plus simultaneous: FIFO full, ackin=1 and core_valid=1 -> the first edge only pops (core_ready was 0); the next edge writes and pops together; count stays 3.
REQ-034 Timestamp (MESH_NI_TIMESTAMP_EN defined): write at the 10th cycle after reset -> datain[57:16]=10. With the macro undefined -> field = 0.
REQ-035 Reset mid-operation: 3 flits queued, rst pulsed low asynchronously between edges -> reqin=0 and datain=0 immediately; inj_count=0; no stale flit after release.
REQ-036 Wrap: 2^16 acked flits -> inj_count returns to 0; FIFO pointers wrap with no loss, checked by the scoreboard.
